// File: rtl/clk_period_monitor_pkg.sv
// Shared types and constants for the clock period monitor family.
package clk_mon_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARM     = 2'd1,
    ST_MEASURE = 2'd2
  } mon_state_e;

  localparam int FAIL_CNT_W = 16;

  function automatic logic [FAIL_CNT_W-1:0] sat_inc(input logic [FAIL_CNT_W-1:0] v);
    logic [FAIL_CNT_W-1:0] r;
    if (v == {FAIL_CNT_W{1'b1}}) begin
      r = v;
    end else begin
      r = v + FAIL_CNT_W'(1);
    end
    return r;
  endfunction

endpackage

// File: rtl/clk_period_monitor_if.sv
// Control/status bundle of the clock period monitor; master drives config, slave is the monitor.
interface clk_period_monitor_if #(
  parameter int CNT_W = 16
) ();
  import clk_mon_pkg::*;

  logic                  enable;
  logic                  mon_in;
  logic [CNT_W-1:0]      exp_period;
  logic [CNT_W-1:0]      tolerance;
  logic                  clear_err;
  logic [CNT_W-1:0]      meas_period;
  logic                  meas_valid;
  logic                  period_ok;
  logic                  locked;
  logic                  err_sticky;
  logic                  timeout_err;
  logic [FAIL_CNT_W-1:0] fail_count;

  modport master (
    output enable, mon_in, exp_period, tolerance, clear_err,
    input  meas_period, meas_valid, period_ok, locked, err_sticky, timeout_err, fail_count
  );

  modport slave (
    input  enable, mon_in, exp_period, tolerance, clear_err,
    output meas_period, meas_valid, period_ok, locked, err_sticky, timeout_err, fail_count
  );
endinterface

// File: rtl/clk_period_monitor_sync_rise_detect.sv
// Metastability synchronizer for an asynchronous input followed by a rising-edge pulse.
module sync_rise_detect #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic rise_o
);
  logic [STAGES-1:0] sync_q;
  logic              dly_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= {STAGES{1'b0}};
      dly_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
      dly_q  <= sync_q[STAGES-1];
    end
  end

  assign rise_o = sync_q[STAGES-1] & ~dly_q;
endmodule

// File: rtl/clk_period_monitor.sv
// Measures the period of mon_in in clk cycles, checks it against exp_period +/- tolerance
// and keeps lock, sticky error and failure-count status.
module clk_period_monitor
  import clk_mon_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2,
  parameter int LOCK_COUNT  = 4
) (
  input logic                 clk,
  input logic                 rst,
  clk_period_monitor_if.slave bus
);
  localparam logic [7:0]       LOCK_TGT = 8'(LOCK_COUNT);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic                  rise_s;
  mon_state_e            state_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [CNT_W-1:0]      meas_period_q;
  logic [7:0]            consec_q;
  logic                  meas_valid_q;
  logic                  period_ok_q;
  logic                  locked_q;
  logic                  err_sticky_q;
  logic                  timeout_err_q;
  logic [FAIL_CNT_W-1:0] fail_count_q;

  logic signed [CNT_W:0] diff_d;
  logic [CNT_W:0]        abs_d;
  logic                  ok_d;
  logic [7:0]            consec_inc_d;
  logic [FAIL_CNT_W-1:0] fail_base_d;

  sync_rise_detect #(.STAGES(SYNC_STAGES)) u_sync (
    .clk    (clk),
    .rst    (rst),
    .d_i    (bus.mon_in),
    .rise_o (rise_s)
  );

  // One extra bit keeps the signed difference exact for any pair of CNT_W values.
  always_comb begin
    diff_d = $signed({1'b0, cnt_q}) - $signed({1'b0, bus.exp_period});
    if (diff_d[CNT_W]) begin
      abs_d = $unsigned(-diff_d);
    end else begin
      abs_d = $unsigned(diff_d);
    end
    ok_d = (abs_d <= {1'b0, bus.tolerance});
    if (consec_q < LOCK_TGT) begin
      consec_inc_d = consec_q + 8'd1;
    end else begin
      consec_inc_d = consec_q;
    end
    if (bus.clear_err) begin
      fail_base_d = {FAIL_CNT_W{1'b0}};
    end else begin
      fail_base_d = fail_count_q;
    end
  end

  // Measurement FSM; a failure later in this block overrides a same-cycle clear_err.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      cnt_q         <= {CNT_W{1'b0}};
      meas_period_q <= {CNT_W{1'b0}};
      consec_q      <= 8'd0;
      meas_valid_q  <= 1'b0;
      period_ok_q   <= 1'b0;
      locked_q      <= 1'b0;
      err_sticky_q  <= 1'b0;
      timeout_err_q <= 1'b0;
      fail_count_q  <= {FAIL_CNT_W{1'b0}};
    end else begin
      meas_valid_q <= 1'b0;
      if (bus.clear_err) begin
        err_sticky_q  <= 1'b0;
        timeout_err_q <= 1'b0;
        fail_count_q  <= {FAIL_CNT_W{1'b0}};
      end
      if (!bus.enable) begin
        state_q  <= ST_IDLE;
        cnt_q    <= {CNT_W{1'b0}};
        consec_q <= 8'd0;
        locked_q <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            cnt_q   <= {CNT_W{1'b0}};
            state_q <= ST_ARM;
          end
          ST_ARM: begin
            if (rise_s) begin
              cnt_q   <= CNT_ONE;
              state_q <= ST_MEASURE;
            end
          end
          ST_MEASURE: begin
            if (rise_s) begin
              meas_period_q <= cnt_q;
              meas_valid_q  <= 1'b1;
              period_ok_q   <= ok_d;
              cnt_q         <= CNT_ONE;
              if (ok_d) begin
                consec_q <= consec_inc_d;
                locked_q <= (consec_inc_d == LOCK_TGT);
              end else begin
                consec_q     <= 8'd0;
                locked_q     <= 1'b0;
                err_sticky_q <= 1'b1;
                fail_count_q <= sat_inc(fail_base_d);
              end
            end else if (cnt_q == CNT_MAX) begin
              timeout_err_q <= 1'b1;
              err_sticky_q  <= 1'b1;
              fail_count_q  <= sat_inc(fail_base_d);
              consec_q      <= 8'd0;
              locked_q      <= 1'b0;
              cnt_q         <= {CNT_W{1'b0}};
              state_q       <= ST_ARM;
            end else begin
              cnt_q <= cnt_q + CNT_ONE;
            end
          end
          default: begin
            state_q <= ST_IDLE;
            cnt_q   <= {CNT_W{1'b0}};
          end
        endcase
      end
    end
  end

  assign bus.meas_period = meas_period_q;
  assign bus.meas_valid  = meas_valid_q;
  assign bus.period_ok   = period_ok_q;
  assign bus.locked      = locked_q;
  assign bus.err_sticky  = err_sticky_q;
  assign bus.timeout_err = timeout_err_q;
  assign bus.fail_count  = fail_count_q;
endmodule

// File: tb/tb_clk_period_monitor.sv
// Randomized bench for clk_period_monitor with a cycle-time based reference model.
module tb_clk_period_monitor;
  localparam int CNT_W   = 8;
  localparam int STAGES  = 2;
  localparam int LOCK    = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;

  clk_period_monitor_if #(.CNT_W(CNT_W)) bus ();

  clk_period_monitor #(
    .CNT_W       (CNT_W),
    .SYNC_STAGES (STAGES),
    .LOCK_COUNT  (LOCK)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: mode 0 idle, 1 waiting for first edge, 2 timing since m_last.
  int m_mode;
  int cyc = 0;
  int m_last;
  bit h [0:STAGES];
  int e_period, e_fail, e_consec;
  bit e_valid, e_ok, e_locked, e_sticky, e_timeout;
  bit rand_clear = 1'b0;

  task automatic model_reset();
    m_mode = 0; m_last = 0;
    for (int i = 0; i <= STAGES; i++) h[i] = 1'b0;
    e_period = 0; e_fail = 0; e_consec = 0;
    e_valid = 0; e_ok = 0; e_locked = 0; e_sticky = 0; e_timeout = 0;
  endtask

  task automatic model_edge();
    bit rise, fail, tmo;
    int el, d;
    cyc++;
    if (rst) begin
      model_reset();
      return;
    end
    // a rise sampled at edge k acts on the FSM at edge k+STAGES
    rise = h[STAGES-1] && !h[STAGES];
    for (int i = STAGES; i > 0; i--) h[i] = h[i-1];
    h[0] = bus.mon_in;
    e_valid = 0; fail = 0; tmo = 0;
    if (bus.clear_err) begin
      e_sticky = 0; e_timeout = 0; e_fail = 0;
    end
    if (!bus.enable) begin
      m_mode = 0; e_consec = 0; e_locked = 0;
    end else if (m_mode == 0) begin
      m_mode = 1;
    end else if (m_mode == 1) begin
      if (rise) begin m_mode = 2; m_last = cyc; end
    end else begin
      el = cyc - m_last;
      if (rise) begin
        d = el - int'(bus.exp_period);
        if (d < 0) d = -d;
        e_period = el; e_valid = 1; e_ok = (d <= int'(bus.tolerance)); m_last = cyc;
        if (e_ok) begin
          e_consec = (e_consec < LOCK) ? e_consec + 1 : LOCK;
          e_locked = (e_consec == LOCK);
        end else begin
          fail = 1;
        end
      end else if (el == CNT_MAX) begin
        tmo = 1; fail = 1; m_mode = 1;
      end
    end
    if (fail) begin
      e_sticky = 1;
      if (tmo) e_timeout = 1;
      if (e_fail < 65535) e_fail++;
      e_consec = 0; e_locked = 0;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic compare_all();
    check("meas_valid",  32'(bus.meas_valid),  32'(e_valid));
    check("meas_period", 32'(bus.meas_period), 32'(e_period));
    check("period_ok",   32'(bus.period_ok),   32'(e_ok));
    check("locked",      32'(bus.locked),      32'(e_locked));
    check("err_sticky",  32'(bus.err_sticky),  32'(e_sticky));
    check("timeout_err", 32'(bus.timeout_err), 32'(e_timeout));
    check("fail_count",  32'(bus.fail_count),  32'(e_fail));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic run_periods(input int p, input int n);
    for (int j = 0; j < n; j++) begin
      for (int ph = 0; ph < p; ph++) begin
        bus.mon_in    = (ph < (p + 1) / 2);
        bus.clear_err = rand_clear && ($urandom_range(0, 31) == 0);
        step();
      end
    end
    bus.clear_err = 1'b0;
  endtask

  task automatic async_reset();
    #3 rst = 1'b1;
    #1;
    model_reset();
    check("rst_meas_period", 32'(bus.meas_period), 32'd0);
    check("rst_locked",      32'(bus.locked),      32'd0);
    check("rst_fail_count",  32'(bus.fail_count),  32'd0);
    check("rst_err_sticky",  32'(bus.err_sticky),  32'd0);
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    int fired;
    int nv;
    bus.enable = 1'b0; bus.mon_in = 1'b0; bus.clear_err = 1'b0;
    bus.exp_period = '0; bus.tolerance = '0;
    model_reset();
    repeat (3) step();
    check("reset_valid",  32'(bus.meas_valid), 32'd0);
    check("reset_locked", 32'(bus.locked),     32'd0);
    check("reset_fail",   32'(bus.fail_count), 32'd0);
    rst = 1'b0;
    repeat (2) step();

    // steady P=4 against exp=4 tol=0
    bus.enable = 1'b1; bus.exp_period = 8'd4; bus.tolerance = 8'd0;
    run_periods(4, 8);
    check("p4_meas_period", 32'(bus.meas_period), 32'd4);
    check("p4_locked",      32'(bus.locked),      32'd1);
    check("p4_sticky",      32'(bus.err_sticky),  32'd0);

    // one stretched period, then relock
    run_periods(6, 1);
    run_periods(4, 6);
    check("stretch_fail",   32'(bus.fail_count), 32'd1);
    check("stretch_sticky", 32'(bus.err_sticky), 32'd1);
    check("relock",         32'(bus.locked),     32'd1);

    // P=5 within tol=1, then outside with tol=0
    bus.tolerance = 8'd1;
    run_periods(5, 8);
    check("p5_tol1_locked", 32'(bus.locked),      32'd1);
    check("p5_tol1_period", 32'(bus.meas_period), 32'd5);
    bus.tolerance = 8'd0;
    run_periods(5, 4);
    check("p5_tol0_fail",   32'(bus.fail_count), 32'd5);
    check("p5_tol0_locked", 32'(bus.locked),     32'd0);

    // timeout with clear_err landing on the same cycle
    bus.mon_in = 1'b0; fired = 0;
    for (int i = 0; i < 300; i++) begin
      bus.clear_err = (m_mode == 2) && ((cyc + 1 - m_last) == CNT_MAX);
      if (bus.clear_err) fired++;
      step();
    end
    bus.clear_err = 1'b0;
    check("tmo_clear_fired", 32'(fired),            32'd1);
    check("tmo_timeout",     32'(bus.timeout_err),  32'd1);
    check("tmo_sticky",      32'(bus.err_sticky),   32'd1);
    check("tmo_fail",        32'(bus.fail_count),   32'd1);

    // lone clear
    bus.enable = 1'b0;
    repeat (3) step();
    bus.clear_err = 1'b1; step();
    bus.clear_err = 1'b0; step();
    check("clr_sticky",  32'(bus.err_sticky),  32'd0);
    check("clr_fail",    32'(bus.fail_count),  32'd0);
    check("clr_timeout", 32'(bus.timeout_err), 32'd0);

    // disable while locked, fail count retained, re-enable only arms on the first edge
    bus.enable = 1'b1; bus.exp_period = 8'd4; bus.tolerance = 8'd0;
    run_periods(4, 4); run_periods(6, 1); run_periods(4, 6);
    check("dis_pre_locked", 32'(bus.locked),     32'd1);
    bus.enable = 1'b0;
    step(); step();
    check("dis_locked", 32'(bus.locked),     32'd0);
    check("dis_fail",   32'(bus.fail_count), 32'd1);
    bus.enable = 1'b1; nv = 0;
    for (int ph = 0; ph < 6; ph++) begin
      bus.mon_in = ((ph % 4) < 2);
      step();
      nv += int'(bus.meas_valid);
    end
    check("reenable_no_meas", 32'(nv), 32'd0);
    run_periods(4, 4);
    check("reenable_period", 32'(bus.meas_period), 32'd4);

    // asynchronous reset in the middle of a measurement
    run_periods(4, 3);
    async_reset();
    run_periods(4, 6);

    // randomized segments
    rand_clear = 1'b1;
    for (int s = 0; s < 40; s++) begin
      if ($urandom_range(0, 7) == 0) begin
        bus.enable = 1'b0;
        repeat ($urandom_range(1, 3)) step();
        bus.enable = 1'b1;
      end
      bus.exp_period = 8'($urandom_range(2, 20));
      bus.tolerance  = 8'($urandom_range(0, 3));
      run_periods($urandom_range(2, 20), $urandom_range(1, 6));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
